// File: rtl/netlist_bist_ctrl.sv
// Logic BIST controller: drives LFSR patterns into a combinational netlist and
// compacts its responses into a 16-bit MISR, counting captured patterns.
module netlist_bist_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num_patterns,
    input  logic [13:0] seed,
    output logic [13:0] pat_out,
    input  logic [7:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [15:0] pat_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] num_lat;
    logic [15:0] next_count;
    logic [13:0] next_pat;
    logic [15:0] next_sig;

    // Next LFSR pattern, next MISR value and next count for the RUN capture.
    always_comb begin
        next_pat   = {pat_out[12:0], pat_out[13] ^ pat_out[4] ^ pat_out[2] ^ pat_out[0]};
        next_sig   = ({signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000))
                     ^ {8'h00, resp_in};
        next_count = pat_count + 16'd1;
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat_out   <= 14'h0000;
            signature <= 16'hFFFF;
            pat_count <= 16'h0000;
            num_lat   <= 16'h0000;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        signature <= 16'hFFFF;
                        pat_count <= 16'h0000;
                        num_lat   <= num_patterns;
                        if (num_patterns != 16'h0000) begin
                            // An all-zero seed would lock the LFSR, so substitute 1.
                            pat_out <= (seed == 14'h0000) ? 14'h0001 : seed;
                            state   <= RUN;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    signature <= next_sig;
                    pat_out   <= next_pat;
                    pat_count <= next_count;
                    if (next_count == num_lat) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
